// File: rtl/fft_pkg.sv
// Shared constants and types for the FFT front-end input reorder buffer.
package fft_pkg;

    localparam int unsigned SAMPLE_W     = 16;
    localparam int unsigned TW_FRAC_BITS = 14;

    // Unity twiddle W0 = 1.0 + j0 in Q2.14.
    localparam logic signed [SAMPLE_W-1:0] W0_REAL = SAMPLE_W'(1 << TW_FRAC_BITS);
    localparam logic signed [SAMPLE_W-1:0] W0_IMAG = '0;

    typedef enum logic {
        ST_FILL  = 1'b0,
        ST_DRAIN = 1'b1
    } fsm_state_t;

    // One complex sample as stored in the reorder buffer.
    typedef struct packed {
        logic signed [SAMPLE_W-1:0] re;
        logic signed [SAMPLE_W-1:0] im;
    } sample_t;

endpackage

// File: rtl/fft_input_reorder_bit_reverse.sv
// Combinational bit-reversal of an address, used for the DIT input order.
module bit_reverse #(
    parameter int unsigned WIDTH = 3
) (
    input  logic [WIDTH-1:0] i_addr,
    output logic [WIDTH-1:0] o_addr_rev_c
);

    // Mirror the address bits: bit i of the result is bit WIDTH-1-i of the input.
    always_comb begin
        o_addr_rev_c = '0;
        for (int i = 0; i < WIDTH; i++) begin
            o_addr_rev_c[i] = i_addr[WIDTH-1-i];
        end
    end

endmodule

// File: rtl/fft_input_reorder.sv
// FFT input reorder buffer: collects N complex samples (FILL), then presents
// them as N/2 stage-1 butterfly pairs (DRAIN) with the unity twiddle.
// Build option: define FFT_BITREV_EN to store samples at bit-reversed
// addresses (DIT input order); otherwise samples are stored in natural order.
module fft_input_reorder
    import fft_pkg::*;
#(
    parameter int unsigned N_LOG2 = 3
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       s_valid,
    output logic                       s_ready,
    input  logic signed [SAMPLE_W-1:0] s_real,
    input  logic signed [SAMPLE_W-1:0] s_imag,
    output logic                       m_valid,
    input  logic                       m_ready,
    output logic signed [SAMPLE_W-1:0] in1_real,
    output logic signed [SAMPLE_W-1:0] in1_imag,
    output logic signed [SAMPLE_W-1:0] in2_real,
    output logic signed [SAMPLE_W-1:0] in2_imag,
    output logic signed [SAMPLE_W-1:0] twiddle_real,
    output logic signed [SAMPLE_W-1:0] twiddle_imag,
    output logic                       m_last
);

    localparam int unsigned N    = 1 << N_LOG2;
    localparam int unsigned HALF = N / 2;
    localparam int unsigned K_W  = (N_LOG2 > 1) ? N_LOG2 - 1 : 1;

    fsm_state_t          r_state;
    fsm_state_t          w_state_nxt;
    logic [N_LOG2-1:0]   r_wr_cnt;
    logic [N_LOG2-1:0]   w_wr_cnt_nxt;
    logic [K_W-1:0]      r_k;
    logic [K_W-1:0]      w_k_nxt;

    sample_t             r_mem [N];

    logic [N_LOG2-1:0]   w_wr_addr;
    logic [N_LOG2-1:0]   w_even_addr;
    logic [N_LOG2-1:0]   w_odd_addr;
    sample_t             w_sample;
    sample_t             w_even;
    sample_t             w_odd;
    logic                w_wr_en;
    logic                w_last_wr;
    logic                w_pair_fire;
    logic                w_last_pair;
    logic                w_drain_nxt;

    logic                r_s_ready;
    logic                r_m_valid;
    logic                r_m_last;
    sample_t             r_in1;
    sample_t             r_in2;
    logic signed [SAMPLE_W-1:0] r_tw_re;
    logic signed [SAMPLE_W-1:0] r_tw_im;

`ifdef FFT_BITREV_EN
    bit_reverse #(
        .WIDTH (N_LOG2)
    ) u_bit_reverse (
        .i_addr       (r_wr_cnt),
        .o_addr_rev_c (w_wr_addr)
    );
`else
    assign w_wr_addr = r_wr_cnt;
`endif

    assign w_sample    = '{re: s_real, im: s_imag};
    assign w_wr_en     = (r_state == ST_FILL) && s_valid;
    assign w_last_wr   = (r_wr_cnt == N_LOG2'(N - 1));
    assign w_pair_fire = (r_state == ST_DRAIN) && m_ready;
    assign w_last_pair = (r_k == K_W'(HALF - 1));

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_FILL;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state, write counter and pair index update.
    always_comb begin
        w_state_nxt  = r_state;
        w_wr_cnt_nxt = r_wr_cnt;
        w_k_nxt      = r_k;
        case (r_state)
            ST_FILL: begin
                if (w_wr_en) begin
                    w_wr_cnt_nxt = r_wr_cnt + N_LOG2'(1);
                    if (w_last_wr) begin
                        w_state_nxt  = ST_DRAIN;
                        w_wr_cnt_nxt = '0;
                    end
                end
            end
            ST_DRAIN: begin
                if (w_pair_fire) begin
                    if (w_last_pair) begin
                        w_state_nxt = ST_FILL;
                        w_k_nxt     = '0;
                    end else begin
                        w_k_nxt = r_k + K_W'(1);
                    end
                end
            end
            default: begin
                w_state_nxt = ST_FILL;
            end
        endcase
    end

    // Operand fetch for the pair shown next cycle; forwards the sample being
    // written on the frame-closing edge so the first pair has no extra delay.
    always_comb begin
        w_even_addr = N_LOG2'({w_k_nxt, 1'b0});
        w_odd_addr  = w_even_addr | N_LOG2'(1);
        w_even      = r_mem[w_even_addr];
        w_odd       = r_mem[w_odd_addr];
        if (w_wr_en && (w_wr_addr == w_even_addr)) begin
            w_even = w_sample;
        end
        if (w_wr_en && (w_wr_addr == w_odd_addr)) begin
            w_odd = w_sample;
        end
    end

    assign w_drain_nxt = (w_state_nxt == ST_DRAIN);

    // Counters and registered output stage.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_cnt  <= '0;
            r_k       <= '0;
            r_s_ready <= 1'b1;
            r_m_valid <= 1'b0;
            r_m_last  <= 1'b0;
            r_in1     <= '0;
            r_in2     <= '0;
            r_tw_re   <= '0;
            r_tw_im   <= '0;
        end else begin
            r_wr_cnt  <= w_wr_cnt_nxt;
            r_k       <= w_k_nxt;
            r_s_ready <= !w_drain_nxt;
            r_m_valid <= w_drain_nxt;
            r_m_last  <= w_drain_nxt && (w_k_nxt == K_W'(HALF - 1));
            if (w_drain_nxt) begin
                r_in1   <= w_even;
                r_in2   <= w_odd;
                r_tw_re <= W0_REAL;
                r_tw_im <= W0_IMAG;
            end else begin
                r_in1   <= '0;
                r_in2   <= '0;
                r_tw_re <= '0;
                r_tw_im <= '0;
            end
        end
    end

    // Sample buffer write; contents survive reset by design.
    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_mem[w_wr_addr] <= w_sample;
        end
    end

    assign s_ready      = r_s_ready;
    assign m_valid      = r_m_valid;
    assign m_last       = r_m_last;
    assign in1_real     = r_in1.re;
    assign in1_imag     = r_in1.im;
    assign in2_real     = r_in2.re;
    assign in2_imag     = r_in2.im;
    assign twiddle_real = r_tw_re;
    assign twiddle_imag = r_tw_im;

endmodule

// File: tb/tb_fft_input_reorder.sv
// Scoreboard bench for fft_input_reorder (N = 8); expected pair order follows
// FFT_BITREV_EN so the same bench covers both builds.
module tb_fft_input_reorder;

    logic               clk = 1'b0;
    logic               rst;
    logic               s_valid;
    logic               s_ready;
    logic signed [15:0] s_real;
    logic signed [15:0] s_imag;
    logic               m_valid;
    logic               m_ready;
    logic signed [15:0] in1_real;
    logic signed [15:0] in1_imag;
    logic signed [15:0] in2_real;
    logic signed [15:0] in2_imag;
    logic signed [15:0] twiddle_real;
    logic signed [15:0] twiddle_imag;
    logic               m_last;

    typedef struct {
        logic signed [15:0] r1;
        logic signed [15:0] i1;
        logic signed [15:0] r2;
        logic signed [15:0] i2;
        logic               last;
    } pair_t;

    pair_t sb[$];
    int    n_checks = 0;
    int    n_fail   = 0;

    // Sample index stored at buffer address a (hand-derived for N = 8).
`ifdef FFT_BITREV_EN
    int perm[8] = '{0, 4, 2, 6, 1, 5, 3, 7};
`else
    int perm[8] = '{0, 1, 2, 3, 4, 5, 6, 7};
`endif

    always #5 clk = ~clk;

    fft_input_reorder #(.N_LOG2(3)) dut (
        .clk          (clk),
        .rst          (rst),
        .s_valid      (s_valid),
        .s_ready      (s_ready),
        .s_real       (s_real),
        .s_imag       (s_imag),
        .m_valid      (m_valid),
        .m_ready      (m_ready),
        .in1_real     (in1_real),
        .in1_imag     (in1_imag),
        .in2_real     (in2_real),
        .in2_imag     (in2_imag),
        .twiddle_real (twiddle_real),
        .twiddle_imag (twiddle_imag),
        .m_last       (m_last)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Queue the four pairs expected from a frame with real = base+i, imag = -(base+i).
    task automatic push_frame(input int base);
        pair_t p;
        for (int k = 0; k < 4; k++) begin
            p.r1   = 16'(base + perm[2*k]);
            p.i1   = 16'(-(base + perm[2*k]));
            p.r2   = 16'(base + perm[2*k+1]);
            p.i2   = 16'(-(base + perm[2*k+1]));
            p.last = (k == 3);
            sb.push_back(p);
        end
    endtask

    // Present one sample and return #1 after the edge that accepts it.
    task automatic send_sample(input int v);
        logic ok;
        logic accepted;
        accepted = 1'b0;
        s_valid  = 1'b1;
        s_real   = 16'(v);
        s_imag   = 16'(-v);
        for (int t = 0; t < 50; t++) begin
            ok = s_ready;
            @(posedge clk);
            #1;
            if (ok) begin
                accepted = 1'b1;
                break;
            end
        end
        if (!accepted) check("accept_timeout", 32'd0, 32'd1);
    endtask

    task automatic send_frame(input int base);
        for (int i = 0; i < 8; i++) send_sample(base + i);
    endtask

    // Monitor: compare every handshaken pair against the scoreboard head.
    initial begin
        pair_t p;
        forever begin
            @(negedge clk);
            if (!rst && m_valid && m_ready) begin
                if (sb.size() == 0) begin
                    check("unexpected_pair", 32'd1, 32'd0);
                end else begin
                    p = sb.pop_front();
                    check("pair_in1_real", 32'(in1_real), 32'(p.r1));
                    check("pair_in1_imag", 32'(in1_imag), 32'(p.i1));
                    check("pair_in2_real", 32'(in2_real), 32'(p.r2));
                    check("pair_in2_imag", 32'(in2_imag), 32'(p.i2));
                    check("pair_m_last", 32'(m_last), 32'(p.last));
                    check("twiddle_real", 32'(twiddle_real), 32'(16'sd16384));
                    check("twiddle_imag", 32'(twiddle_imag), 32'd0);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected test completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst     = 1'b1;
        s_valid = 1'b0;
        s_real  = '0;
        s_imag  = '0;
        m_ready = 1'b0;

        // Reset state.
        #3;
        check("rst_s_ready", 32'(s_ready), 32'd1);
        check("rst_m_valid", 32'(m_valid), 32'd0);
        check("rst_m_last", 32'(m_last), 32'd0);
        check("rst_in1_real", 32'(in1_real), 32'd0);
        check("rst_twiddle_real", 32'(twiddle_real), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Full-rate frame: latency 1, four pairs on four consecutive cycles.
        m_ready = 1'b1;
        push_frame(0);
        send_frame(0);
        s_valid = 1'b0;
        check("first_pair_latency", 32'(m_valid), 32'd1);
        check("drain_s_ready_low", 32'(s_ready), 32'd0);
        repeat (4) @(posedge clk);
        #1;
        check("frame1_done_s_ready", 32'(s_ready), 32'd1);
        check("frame1_done_m_valid", 32'(m_valid), 32'd0);
        check("frame1_sb_empty", 32'(sb.size()), 32'd0);

        // Backpressure on pair 1 for three cycles.
        push_frame(0);
        send_frame(0);
        s_valid = 1'b0;
        @(posedge clk);
        #1;
        m_ready = 1'b0;
        for (int h = 0; h < 3; h++) begin
            @(negedge clk);
            check("hold_m_valid", 32'(m_valid), 32'd1);
            check("hold_in1_real", 32'(in1_real), 32'(perm[2]));
            check("hold_in2_real", 32'(in2_real), 32'(perm[3]));
            check("hold_m_last", 32'(m_last), 32'd0);
            @(posedge clk);
            #1;
        end
        m_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("bp_done_s_ready", 32'(s_ready), 32'd1);
        check("bp_sb_empty", 32'(sb.size()), 32'd0);

        // Sample 99 offered throughout DRAIN must be ignored.
        push_frame(100);
        send_frame(100);
        s_real  = 16'sd99;
        s_imag  = 16'sd99;
        m_ready = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("ignore_s_ready", 32'(s_ready), 32'd0);
            @(posedge clk);
            #1;
        end
        m_ready = 1'b1;
        repeat (4) begin
            @(negedge clk);
            check("ignore_s_ready_drain", 32'(s_ready), 32'd0);
            @(posedge clk);
            #1;
        end
        s_valid = 1'b0;
        check("ignore_back_to_fill", 32'(s_ready), 32'd1);
        push_frame(30);
        send_frame(30);
        s_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("clean_frame_sb_empty", 32'(sb.size()), 32'd0);

        // Reset after five samples discards the partial frame.
        for (int i = 0; i < 5; i++) send_sample(50 + i);
        s_valid = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        check("midfill_rst_s_ready", 32'(s_ready), 32'd1);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        push_frame(10);
        send_frame(10);
        s_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("after_rst_sb_empty", 32'(sb.size()), 32'd0);

        // Asynchronous reset in the middle of a stalled DRAIN.
        m_ready = 1'b0;
        push_frame(60);
        send_frame(60);
        s_valid = 1'b0;
        @(posedge clk);
        #3;
        check("pre_rst_m_valid", 32'(m_valid), 32'd1);
        rst = 1'b1;
        #1;
        check("async_rst_s_ready", 32'(s_ready), 32'd1);
        check("async_rst_m_valid", 32'(m_valid), 32'd0);
        check("async_rst_m_last", 32'(m_last), 32'd0);
        check("async_rst_in1_real", 32'(in1_real), 32'd0);
        check("async_rst_in1_imag", 32'(in1_imag), 32'd0);
        check("async_rst_in2_real", 32'(in2_real), 32'd0);
        check("async_rst_in2_imag", 32'(in2_imag), 32'd0);
        check("async_rst_tw_real", 32'(twiddle_real), 32'd0);
        check("async_rst_tw_imag", 32'(twiddle_imag), 32'd0);
        sb.delete();
        @(negedge clk);
        rst = 1'b0;

        // One more frame after the DRAIN reset must start clean.
        m_ready = 1'b1;
        @(posedge clk);
        #1;
        push_frame(200);
        send_frame(200);
        s_valid = 1'b0;
        for (int t = 0; t < 20 && sb.size() != 0; t++) @(posedge clk);
        #1;
        check("final_sb_empty", 32'(sb.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fft_input_reorder.md
FFT_INPUT_REORDER -- requirements
Module: fft_input_reorder

Interface
REQ-001 The block SHALL have parameter N_LOG2, default 3, meaning log2 of the FFT size N (N = 8 points by default).
REQ-002 The block SHALL have port clk, input, 1 bit, the single clock; all logic is rising-edge.
REQ-003 The block SHALL have port rst, input, 1 bit, reset that is asynchronous and active-high.
REQ-004 The block SHALL have port s_valid, input, 1 bit, meaning the input sample is valid.
REQ-005 The block SHALL have port s_ready, output, 1 bit, meaning the block accepts a sample this cycle.
REQ-006 The block SHALL have ports s_real and s_imag, input, 16 bits each, signed two's-complement sample.
REQ-007 The block SHALL have port m_valid, output, 1 bit, meaning a butterfly pair is presented.
REQ-008 The block SHALL have port m_ready, input, 1 bit, meaning the downstream stage-1 butterfly consumes the pair.
REQ-009 The block SHALL have ports in1_real, in1_imag, in2_real and in2_imag, output, 16 bits each, the pair operands.
REQ-010 The block SHALL have ports twiddle_real and twiddle_imag, output, 16 bits each, Q2.14 twiddle.
REQ-011 The block SHALL have port m_last, output, 1 bit, marking the final pair of a frame.

Function
REQ-012 The block SHALL implement a two-state FSM: FILL, then DRAIN.
REQ-013 FILL: s_ready = 1 and m_valid = 0; a sample is written when s_valid & s_ready; the write address is bitrev(wr_cnt) over N_LOG2 bits; wr_cnt increments.
REQ-014 FILL -> DRAIN SHALL occur on the clock edge that accepts sample N-1; wr_cnt then wraps to 0.
REQ-015 DRAIN: s_ready = 0, and s_valid SHALL be ignored with no write and no counter change.
REQ-016 DRAIN: m_valid = 1; pair k (k = 0..N/2-1) is in1 = mem[2k] and in2 = mem[2k+1].
REQ-017 DRAIN: the twiddle SHALL be the constant W0 = (16384, 0).
REQ-018 A pair SHALL advance on m_valid & m_ready; the outputs stay stable while m_valid & !m_ready.
REQ-019 m_last SHALL be 1 exactly when k = N/2-1 and m_valid = 1.
REQ-020 The handshake on the last pair SHALL return the FSM to FILL and wrap k to 0; s_ready rises the next cycle, so there is no overlap between frames.
REQ-021 First-pair latency SHALL be 1 cycle after the accepting edge of sample N-1; throughput is 1 pair per cycle with m_ready held at 1.
REQ-022 The data path SHALL be pass-through only, with no arithmetic and no width growth; stage-1 growth to 33 bits is downstream.

Reset
REQ-023 While rst = 1, the FSM SHALL be FILL, with wr_cnt = 0, k = 0, s_ready = 1, m_valid = 0 and m_last = 0; all pair and twiddle outputs are 0.
REQ-024 Assertion of rst mid-FILL or mid-DRAIN SHALL discard the partial frame; memory contents need not be cleared.
REQ-025 After deassertion of rst, the first accepted sample SHALL be treated as sample 0 of a new frame.

Configuration
REQ-026 With macro FFT_BITREV_EN defined, the write address SHALL be bit-reversed, giving the DIT input order of REQ-013.
REQ-027 With FFT_BITREV_EN undefined, the write address SHALL be wr_cnt in natural order; all other behaviour is unchanged.

Structure
REQ-028 Shared package fft_pkg SHALL hold: the sample width constant (16), the twiddle fraction bits (14), the W0 constants (16384, 0) and the FSM state type.
REQ-029 One combinational sub-module, bit_reverse, parameterised by width, SHALL compute the write address; the buffer is an internal N x 32-bit register array.

Verification
REQ-030 Reset test: assert rst mid-cycle -> s_ready = 1, m_valid = 0, all outputs 0, asynchronously and before the next edge.
REQ-031 Bit-reversed frame test: FFT_BITREV_EN defined, N = 8, real = 0..7, imag = 0, continuous valid, m_ready = 1 -> pairs (0,4), (2,6), (1,5), (3,7) on 4 consecutive cycles, twiddle (16384, 0), m_last on the 4th pair only.
REQ-032 Backpressure test: hold m_ready = 0 for 3 cycles on pair 1 -> (2,6) held stable, and the next pair appears only after the handshake.
REQ-033 Drain-ignore test: s_valid = 1 with value 99 during DRAIN -> s_ready = 0, no 99 appears in any pair, and the next frame starts clean.
REQ-034 Mid-frame reset test: feed 5 samples, assert rst, then feed 10..17 -> pairs (10,14), (12,16), (11,15), (13,17).
REQ-035 Natural-order test: FFT_BITREV_EN undefined, real = 0..7 -> pairs (0,1), (2,3), (4,5), (6,7).
